// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: data-memory control encodings,
// port FSM states and the store lane record.
package mem_access_unit_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } port_state_e;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wea;
  } store_lane_t;

endpackage

// File: rtl/mem_access_unit_store_buffer.sv
// Circular store buffer holding {word address, write data, byte enables};
// also reports whether any occupied entry targets a given word address.
module store_buffer_fifo #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [31:0]       push_data,
  input  logic [3:0]        push_wea,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [31:0]       head_data,
  output logic [3:0]        head_wea,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [SB_DEPTH];
  logic [31:0]       data_mem [SB_DEPTH];
  logic [3:0]        wea_mem  [SB_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [SB_DEPTH-1:0] hit_vec;

  // NOTE: entry storage has no reset; occupancy is tracked by head/tail/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
      wea_mem[tail]  <= push_wea;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // An entry is occupied when its distance from head is below count.
  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] offset;
    assign offset     = PTR_W'(i) - head;
    assign hit_vec[i] = ({1'b0, offset} < count) && (addr_mem[i] == match_addr);
  end

  assign match     = |hit_vec;
  assign full      = (count == CNT_W'(SB_DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];
  assign head_wea  = wea_mem[head];

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: store forwarding and lane alignment, buffered stores
// draining over a req/ack port, and loads with lane extraction and extension.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_in,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  input  logic [2:0]        dm_ctrl_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       rs2_data_in,
  input  logic              forwardC,
  input  logic [31:0]       wb_fwd_data,
  output logic              stall_out,
  output logic              load_valid_out,
  output logic [31:0]       load_data_out,
  output logic              misalign_out,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_wea,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
    logic r;
    case (ctrl)
      dm_word:                           r = (lo != 2'b00);
      dm_halfword, dm_halfword_unsigned: r = lo[0];
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic store_lane_t store_align(input logic [2:0] ctrl, input logic [1:0] lo,
                                              input logic [31:0] d);
    store_lane_t r;
    case (ctrl)
      dm_byte, dm_byte_unsigned: begin
        r.wdata = {4{d[7:0]}};
        r.wea   = 4'b0001 << lo;
      end
      dm_halfword, dm_halfword_unsigned: begin
        r.wdata = {2{d[15:0]}};
        r.wea   = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        r.wdata = d;
        r.wea   = 4'b1111;
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] ctrl, input logic [1:0] lo,
                                               input logic [31:0] w);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] r;
    shifted = w >> {lo, 3'b000};
    half    = lo[1] ? w[31:16] : w[15:0];
    byte_v  = shifted[7:0];
    case (ctrl)
      dm_halfword:          r = {{16{half[15]}}, half};
      dm_halfword_unsigned: r = {16'h0000, half};
      dm_byte:              r = {{24{byte_v[7]}}, byte_v};
      dm_byte_unsigned:     r = {24'h000000, byte_v};
      default:              r = w;
    endcase
    return r;
  endfunction

  port_state_e       state_q, state_d;
  logic              is_load, is_store, misalign, load_pres, store_pres;
  logic              sb_full, sb_empty, sb_match, hazard_q, hit, head_ack;
  logic              accept, load_go, sb_push;
  logic [ADDR_W-1:0] word_addr, head_addr;
  logic [31:0]       head_data;
  logic [3:0]        head_wea;
  logic [1:0]        ld_lo_q;
  logic [2:0]        ld_ctrl_q;
  store_lane_t       lane;

  // Read wins when both strobes are set; misaligned accesses are dropped, never stalled on.
  assign is_load    = mem_read_in;
  assign is_store   = mem_write_in & ~mem_read_in;
  assign misalign   = (is_load | is_store) & is_misaligned(dm_ctrl_in, addr_in[1:0]);
  assign load_pres  = valid_in & is_load & ~misalign;
  assign store_pres = valid_in & is_store & ~misalign;
  assign word_addr  = {addr_in[ADDR_W-1:2], 2'b00};
  assign lane       = store_align(dm_ctrl_in, addr_in[1:0], forwardC ? wb_fwd_data : rs2_data_in);

  // Once a load hits, it waits for the whole buffer to empty, not just the matching entry.
  assign hit      = (sb_match | hazard_q) & ~sb_empty;
  assign head_ack = (state_q == ST_STORE) & dm_ack;
  assign stall_out = (load_pres & ((state_q != ST_IDLE) | hit))
                   | (store_pres & sb_full & ~head_ack)
                   | (state_q == ST_LOAD);
  assign accept   = valid_in & ~stall_out;
  assign load_go  = accept & load_pres;
  assign sb_push  = accept & store_pres;

  store_buffer_fifo #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .push      (sb_push),
    .push_addr (word_addr),
    .push_data (lane.wdata),
    .push_wea  (lane.wea),
    .pop       (head_ack),
    .full      (sb_full),
    .empty     (sb_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_wea  (head_wea),
    .match_addr(word_addr),
    .match     (sb_match)
  );

  // NOTE: next state defaults to the current state so every path assigns it (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_go)        state_d = ST_LOAD;
        else if (!sb_empty) state_d = ST_STORE;
      end
      ST_LOAD:  if (dm_ack) state_d = ST_IDLE;
      ST_STORE: if (dm_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      hazard_q       <= 1'b0;
      ld_lo_q        <= 2'b00;
      ld_ctrl_q      <= dm_word;
      dm_req         <= 1'b0;
      dm_we          <= 1'b0;
      dm_addr        <= '0;
      dm_wdata       <= '0;
      dm_wea         <= '0;
      load_valid_out <= 1'b0;
      load_data_out  <= '0;
      misalign_out   <= 1'b0;
    end else begin
      state_q        <= state_d;
      hazard_q       <= load_pres & (sb_match | hazard_q) & ~sb_empty;
      misalign_out   <= valid_in & ~stall_out & misalign;
      load_valid_out <= (state_q == ST_LOAD) & dm_ack;
      if ((state_q == ST_LOAD) && dm_ack)
        load_data_out <= load_extract(ld_ctrl_q, ld_lo_q, dm_rdata);

      if (state_q == ST_IDLE && state_d == ST_LOAD) begin
        dm_req    <= 1'b1;
        dm_we     <= 1'b0;
        dm_addr   <= word_addr;
        dm_wdata  <= '0;
        dm_wea    <= '0;
        ld_lo_q   <= addr_in[1:0];
        ld_ctrl_q <= dm_ctrl_in;
      end else if (state_q == ST_IDLE && state_d == ST_STORE) begin
        dm_req   <= 1'b1;
        dm_we    <= 1'b1;
        dm_addr  <= head_addr;
        dm_wdata <= head_data;
        dm_wea   <= head_wea;
      end else if (state_q != ST_IDLE && dm_ack) begin
        dm_req   <= 1'b0;
        dm_we    <= 1'b0;
        dm_addr  <= '0;
        dm_wdata <= '0;
        dm_wea   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory responder and a
// scoreboard of expected memory writes and load results.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_in, mem_write_in, mem_read_in, forwardC;
  logic [2:0]  dm_ctrl_in;
  logic [31:0] addr_in, rs2_data_in, wb_fwd_data;
  logic        stall_out, load_valid_out, misalign_out;
  logic [31:0] load_data_out;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wea;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wea;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_load[$];
  logic [31:0] mem [logic [31:0]];
  bit          manual = 1'b0;
  int          n_pass = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_access_unit #(.SB_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .mem_write_in(mem_write_in),
    .mem_read_in(mem_read_in), .dm_ctrl_in(dm_ctrl_in), .addr_in(addr_in),
    .rs2_data_in(rs2_data_in), .forwardC(forwardC), .wb_fwd_data(wb_fwd_data),
    .stall_out(stall_out), .load_valid_out(load_valid_out), .load_data_out(load_data_out),
    .misalign_out(misalign_out), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wea(dm_wea), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet_outputs(input string p);
    check({p, "_stall"},      32'(stall_out), 32'd0);
    check({p, "_load_valid"}, 32'(load_valid_out), 32'd0);
    check({p, "_load_data"},  load_data_out, 32'd0);
    check({p, "_misalign"},   32'(misalign_out), 32'd0);
    check({p, "_dm_req"},     32'(dm_req), 32'd0);
    check({p, "_dm_we"},      32'(dm_we), 32'd0);
    check({p, "_dm_addr"},    dm_addr, 32'd0);
    check({p, "_dm_wdata"},   dm_wdata, 32'd0);
    check({p, "_dm_wea"},     32'(dm_wea), 32'd0);
  endtask

  // Present one access, wait (bounded) for it to be accepted, then release the bus.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic fwd, input logic [31:0] fwd_data, output int waited);
    valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; dm_ctrl_in = ctrl;
    addr_in = addr; rs2_data_in = data; forwardC = fwd; wb_fwd_data = fwd_data;
    #1;
    waited = 0;
    while (stall_out && waited < 60) begin
      @(posedge clk);
      #3;
      waited++;
    end
    check("accept", 32'(stall_out), 32'd0);
    @(posedge clk);
    #2;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; forwardC = 1'b0;
  endtask

  function automatic wr_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    wr_t r;
    r.addr = a; r.data = d; r.wea = w;
    return r;
  endfunction

  // Memory responder: zero-wait ack while a request is up, unless the test drives dm_ack itself.
  always @(posedge clk) begin
    #1;
    if (!manual) begin
      if (dm_req) begin
        dm_ack = 1'b1;
        if (dm_we) begin
          logic [31:0] w;
          w = mem.exists(dm_addr) ? mem[dm_addr] : 32'd0;
          for (int b = 0; b < 4; b++)
            if (dm_wea[b]) w[8*b +: 8] = dm_wdata[8*b +: 8];
          mem[dm_addr] = w;
        end else begin
          dm_rdata = mem.exists(dm_addr) ? mem[dm_addr] : 32'd0;
        end
      end else begin
        dm_ack = 1'b0;
      end
    end
  end

  // Scoreboard: compare completed writes and load results against queued expectations.
  always @(negedge clk) begin
    if (rstn && dm_req && dm_ack && dm_we) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write_addr", dm_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr",  dm_addr, e.addr);
        check("wr_wdata", dm_wdata, e.data);
        check("wr_wea",   32'(dm_wea), 32'(e.wea));
      end
    end
    if (load_valid_out) begin
      if (exp_load.size() == 0) check("unexpected_load", load_data_out, 32'hFFFF_FFFF);
      else                      check("load_data", load_data_out, exp_load.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rstn = 1'b0; valid_in = 1'b0; mem_write_in = 1'b0; mem_read_in = 1'b0;
    dm_ctrl_in = dm_word; addr_in = '0; rs2_data_in = '0; forwardC = 1'b0;
    wb_fwd_data = '0; dm_ack = 1'b0; dm_rdata = '0;
    mem[32'h100] = 32'h1122_3344;
    mem[32'h200] = 32'h1280_3456;
    mem[32'h300] = 32'hDEAD_BEEF;
    mem[32'h400] = 32'hCAFE_F00D;

    tick(); tick();
    check_quiet_outputs("reset");
    #1 rstn = 1'b1;
    tick();

    // lb: extraction with sign extension and the two-cycle minimum latency
    exp_load.push_back(32'h0000_0034);
    issue(1, 0, dm_byte, 32'h201, 0, 0, 0, w);
    check("lb201_req",  32'(dm_req), 32'd1);
    check("lb201_we",   32'(dm_we), 32'd0);
    check("lb201_addr", dm_addr, 32'h200);
    tick();
    check("lb201_valid_t2", 32'(load_valid_out), 32'd1);
    tick();
    check("lb201_valid_t3", 32'(load_valid_out), 32'd0);
    exp_load.push_back(32'hFFFF_FF80);
    issue(1, 0, dm_byte, 32'h202, 0, 0, 0, w);
    tick();
    check("lb202_valid_t2", 32'(load_valid_out), 32'd1);
    tick(); tick();

    // sb to 0x103 then lhu from 0x102 after the drain
    exp_wr.push_back(mk_wr(32'h100, 32'hA5A5_A5A5, 4'b1000));
    issue(0, 1, dm_byte, 32'h103, 32'h0000_00A5, 0, 0, w);
    repeat (4) tick();
    exp_load.push_back(32'h0000_A522);
    issue(1, 0, dm_halfword_unsigned, 32'h102, 0, 0, 0, w);
    repeat (3) tick();

    // misaligned lw and sh: pulse, dropped, no memory traffic
    issue(1, 0, dm_word, 32'h102, 0, 0, 0, w);
    check("lw_mis_pulse", 32'(misalign_out), 32'd1);
    check("lw_mis_req",   32'(dm_req), 32'd0);
    tick();
    check("lw_mis_end",   32'(misalign_out), 32'd0);
    issue(0, 1, dm_halfword, 32'h101, 32'h1234_5678, 0, 0, w);
    check("sh_mis_pulse", 32'(misalign_out), 32'd1);
    tick(); tick();
    check("sh_mis_no_req", 32'(dm_req), 32'd0);

    // sw with store-data forwarding from WB
    exp_wr.push_back(mk_wr(32'h500, 32'hCAFE_BABE, 4'b1111));
    issue(0, 1, dm_word, 32'h500, 32'h1111_1111, 1, 32'hCAFE_BABE, w);
    repeat (4) tick();

    // Fill the buffer with ack held low, then a fifth store waits for the head ack
    manual = 1'b1;
    dm_ack = 1'b0;
    for (int i = 0; i < 5; i++)
      exp_wr.push_back(mk_wr(32'h600 + 32'(4*i), 32'(i + 1), 4'b1111));
    for (int i = 0; i < 4; i++) begin
      issue(0, 1, dm_word, 32'h600 + 32'(4*i), 32'(i + 1), 0, 0, w);
      check("fill_no_wait", 32'(w), 32'd0);
    end
    valid_in = 1'b1; mem_write_in = 1'b1; dm_ctrl_in = dm_word;
    addr_in = 32'h610; rs2_data_in = 32'd5;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("full_stall", 32'(stall_out), 32'd1);
      @(posedge clk);
      #3;
    end
    check("full_req_held", 32'(dm_req), 32'd1);
    dm_ack = 1'b1;
    #1;
    check("full_ack_accepts", 32'(stall_out), 32'd0);
    @(posedge clk);
    #2;
    valid_in = 1'b0; mem_write_in = 1'b0; dm_ack = 1'b0;
    manual = 1'b0;
    repeat (12) tick();

    // Load hitting a buffered store waits for the drain and sees the new value
    exp_wr.push_back(mk_wr(32'h300, 32'h5566_7788, 4'b1111));
    exp_load.push_back(32'h5566_7788);
    issue(0, 1, dm_word, 32'h300, 32'h5566_7788, 0, 0, w);
    issue(1, 0, dm_word, 32'h300, 0, 0, 0, w);
    check("hazard_stalled", 32'(w > 0), 32'd1);
    repeat (4) tick();

    // Load to an unrelated word goes ahead of a buffered store
    exp_wr.push_back(mk_wr(32'h700, 32'h0BAD_F00D, 4'b1111));
    exp_load.push_back(32'hCAFE_F00D);
    issue(0, 1, dm_word, 32'h700, 32'h0BAD_F00D, 0, 0, w);
    issue(1, 0, dm_word, 32'h400, 0, 0, 0, w);
    check("bypass_no_stall", 32'(w), 32'd0);
    check("bypass_load_first", 32'(dm_we), 32'd0);
    repeat (6) tick();

    // Reset while a drain is in flight; a late ack must not complete anything
    manual = 1'b1;
    dm_ack = 1'b0;
    issue(0, 1, dm_word, 32'h800, 32'hAAAA_AAAA, 0, 0, w);
    issue(0, 1, dm_word, 32'h804, 32'hBBBB_BBBB, 0, 0, w);
    check("mid_drain_req", 32'(dm_req), 32'd1);
    rstn = 1'b0;
    #1;
    check_quiet_outputs("mid_reset");
    #1 rstn = 1'b1;
    tick();
    dm_ack = 1'b1;
    tick();
    check("late_ack_req0", 32'(dm_req), 32'd0);
    tick();
    check("late_ack_req1", 32'(dm_req), 32'd0);
    dm_ack = 1'b0;
    repeat (4) tick();
    check("fifo_cleared", 32'(dm_req), 32'd0);
    manual = 1'b0;

    for (int i = 0; i < 200 && (exp_wr.size() + exp_load.size()) != 0; i++) tick();
    check("scoreboard_empty", 32'(exp_wr.size() + exp_load.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
